fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 The block SHALL provide parameter NOP_INSTR, default 16'h0000, the instruction word inserted on flush or redirect.
REQ-003 The block SHALL have port clk  input  1  the single rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port stall  input  1  hold the PC and the IF/ID register this cycle.
REQ-006 The block SHALL have port flush  input  1  invalidate the IF/ID register this cycle.
REQ-007 The block SHALL have port redirect  input  1  load the PC from redirect_pc (branch/jump taken).
REQ-008 The block SHALL have port redirect_pc  input  16  byte address of the branch/jump target.
REQ-009 The block SHALL have port imem_addr  output  16  byte address to the instruction memory.
REQ-010 The block SHALL have port imem_instr  input  16  instruction word returned combinationally by the instruction memory.
REQ-011 The block SHALL have port if_id_instr  output  16  registered instruction word for decode.
REQ-012 The block SHALL have port if_id_pc_plus2  output  16  registered address of the next sequential instruction.
REQ-013 The block SHALL have port if_id_valid  output  1  the IF/ID contents are a real fetched instruction.

Function
REQ-014 imem_addr SHALL equal the PC register combinationally, so the instruction memory is read in zero cycles.
REQ-015 Instructions are 16-bit, byte-addressed; sequential PC update SHALL be pc+2 modulo 2^16, with 16'hFFFE wrapping to 16'h0000.
REQ-016 PC update priority per edge SHALL be: redirect > stall > increment.
REQ-017 On redirect, PC SHALL load {redirect_pc[15:1],1'b0}; bit 0 is forced to zero and no error is raised.
REQ-018 On stall without redirect, PC SHALL hold its value.
REQ-019 IF/ID update priority per edge SHALL be: redirect or flush > stall > capture.
REQ-020 Capture SHALL load if_id_instr<=imem_instr, if_id_pc_plus2<=pc+2 (wrapped), and if_id_valid<=1.
REQ-021 On redirect or flush, if_id_instr SHALL load NOP_INSTR, if_id_valid SHALL load 0, and if_id_pc_plus2 SHALL hold its value.
REQ-022 On stall without flush or redirect, all IF/ID outputs SHALL hold their values.
REQ-023 Simultaneous flush and stall without redirect SHALL clear IF/ID and hold the PC.
REQ-024 Fetch-to-decode latency SHALL be exactly one clock edge from PC presentation.

Reset
REQ-025 While rst_n=0, the block SHALL hold PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus2=RESET_PC, and if_id_valid=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL override stall, flush, and redirect immediately.
REQ-027 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro FETCH_PERF_CNT_EN defined, the block SHALL add outputs fetch_count[31:0] and stall_count[31:0].
REQ-029 Under FETCH_PERF_CNT_EN, fetch_count SHALL increment on each capture edge and stall_count SHALL increment on each stall edge without redirect.
REQ-030 Under FETCH_PERF_CNT_EN, both counters SHALL wrap silently and reset to 0.
REQ-031 Without FETCH_PERF_CNT_EN, the counter ports and logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-032 Shared package mips_pkg SHALL hold ADDR_W=16, INSTR_W=16, PC_STEP=2, and the default NOP encoding.
REQ-033 The block SHALL contain one sub-module, pc_reg, holding the PC register, redirect/stall/increment priority mux, and alignment masking.
REQ-034 The IF/ID register and perf counters SHALL reside in fetch_stage.

Verification
REQ-035 Bench SHALL use an instruction memory model returning 2 at address 16'h0004 and 24 at address 16'h0030.
REQ-036 Reset release then 3 edges with no controls -> imem_addr sequence 0000, 0002, 0004, 0006; after the third edge if_id_instr=2, if_id_pc_plus2=0006, and if_id_valid=1.
REQ-037 redirect=1 with redirect_pc=16'h0031 for one edge -> PC=0030 and if_id_valid=0 after that edge; after the next edge if_id_instr=24 and if_id_pc_plus2=0032.
REQ-038 stall held 3 edges at PC=0004 -> PC and IF/ID unchanged throughout; with FETCH_PERF_CNT_EN, stall_count increases by 3.
REQ-039 redirect to FFFE, then one free edge -> PC wraps to 0000 and if_id_pc_plus2=0000.
REQ-040 flush and stall together, then rst_n pulsed low mid-cycle -> IF/ID clears with PC held; outputs go to reset values before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and small types for the fetch pipeline:
// address/instruction widths, PC step, default NOP and PC-alignment helper.
package mips_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  PC_STEP     = ADDR_W'(2);
  localparam logic [INSTR_W-1:0] NOP_DEFAULT = '0;

  // Instructions are halfword aligned, so bit 0 of any target is dropped.
  localparam logic [ADDR_W-1:0]  ALIGN_MASK  = ~ADDR_W'(1);

  typedef enum logic [1:0] {
    PC_INC,
    PC_HOLD,
    PC_REDIRECT
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_CAPTURE,
    IFID_HOLD,
    IFID_CLEAR
  } ifid_sel_e;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect > stall > increment priority, with halfword
// alignment of redirect targets and modulo-2^16 sequential stepping.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_next;

  // Unsigned 16-bit add wraps FFFE -> 0000 without extra logic.
  assign pc_plus2 = pc + PC_STEP;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = PC_INC;
    if (redirect)   sel = PC_REDIRECT;
    else if (stall) sel = PC_HOLD;
  end

  always_comb begin
    pc_next = pc_plus2;
    unique case (sel)
      PC_REDIRECT: pc_next = align_pc(redirect_pc);
      PC_HOLD:     pc_next = pc;
      default:     pc_next = pc_plus2;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC (pc_reg), zero-latency imem addressing and the IF/ID register.
// Optional perf counters fetch_count/stall_count are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus2;
  ifid_sel_e         ifid_sel;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus2    (pc_plus2)
  );

  assign imem_addr = pc;

  always_comb begin
    ifid_sel = IFID_CAPTURE;
    if (redirect || flush) ifid_sel = IFID_CLEAR;
    else if (stall)        ifid_sel = IFID_HOLD;
  end

  // A squashed slot keeps its pc_plus2; only the instruction and valid bit are killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= RESET_PC;
      if_id_valid    <= 1'b0;
    end else begin
      unique case (ifid_sel)
        IFID_CLEAR: begin
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        IFID_CAPTURE: begin
          if_id_instr    <= imem_instr;
          if_id_pc_plus2 <= pc_plus2;
          if_id_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ifid_sel == IFID_CAPTURE) fetch_count <= fetch_count + 32'd1;
      if (stall && !redirect)       stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of single-edge vectors plus a
// mid-cycle reset sequence; counter checks compiled in with FETCH_PERF_CNT_EN.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  int unsigned exp_fetch;
  int unsigned exp_stall;
`endif

  int checks;
  int failures;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: 2 at 0004, 24 at 0030, address-tagged filler elsewhere.
  always_comb begin
    if (imem_addr == 16'h0004)      imem_instr = 16'd2;
    else if (imem_addr == 16'h0030) imem_instr = 16'd24;
    else                            imem_instr = 16'hA000 ^ imem_addr;
  end

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc2;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [15:0] pc, input logic [15:0] instr,
                             input logic [15:0] pc2, input logic valid);
    check({name, ".pc"},    {16'h0, imem_addr},      {16'h0, pc});
    check({name, ".instr"}, {16'h0, if_id_instr},    {16'h0, instr});
    check({name, ".pc2"},   {16'h0, if_id_pc_plus2}, {16'h0, pc2});
    check({name, ".valid"}, {31'h0, if_id_valid},    {31'h0, valid});
  endtask

  // Drive controls away from the edge, take one edge, sample 1 ns later.
  task automatic step(input logic s, input logic f, input logic r, input logic [15:0] rp);
    stall = s; flush = f; redirect = r; redirect_pc = rp;
    @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
    if (rst_n) begin
      if (!r && !f && !s) exp_fetch++;
      if (s && !r)        exp_stall++;
    end
`endif
    #1;
  endtask

  task automatic add(input string n, input logic s, input logic f, input logic r, input logic [15:0] rp,
                     input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] pc2, input logic v);
    vec_t t;
    t.name = n; t.stall = s; t.flush = f; t.redirect = r; t.redirect_pc = rp;
    t.exp_pc = pc; t.exp_instr = instr; t.exp_pc2 = pc2; t.exp_valid = v;
    vecs.push_back(t);
  endtask

  initial begin
    checks = 0;
    failures = 0;
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 0;
    exp_stall = 0;
`endif
    //    name          s  f  r  rpc       pc        instr     pc2       v
    add("seq1",        0, 0, 0, 16'h0000, 16'h0002, 16'hA000, 16'h0002, 1);
    add("seq2",        0, 0, 0, 16'h0000, 16'h0004, 16'hA002, 16'h0004, 1);
    add("seq3",        0, 0, 0, 16'h0000, 16'h0006, 16'h0002, 16'h0006, 1);
    add("redir31",     0, 0, 1, 16'h0031, 16'h0030, 16'h0000, 16'h0006, 0);
    add("after_redir", 0, 0, 0, 16'h0000, 16'h0032, 16'h0018, 16'h0032, 1);
    add("redir02",     0, 0, 1, 16'h0002, 16'h0002, 16'h0000, 16'h0032, 0);
    add("fill04",      0, 0, 0, 16'h0000, 16'h0004, 16'hA002, 16'h0004, 1);
    add("stall1",      1, 0, 0, 16'h0000, 16'h0004, 16'hA002, 16'h0004, 1);
    add("stall2",      1, 0, 0, 16'h0000, 16'h0004, 16'hA002, 16'h0004, 1);
    add("stall3",      1, 0, 0, 16'h0000, 16'h0004, 16'hA002, 16'h0004, 1);
    add("unstall",     0, 0, 0, 16'h0000, 16'h0006, 16'h0002, 16'h0006, 1);
    add("redir_stall", 1, 0, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0006, 0);
    add("flush",       0, 1, 0, 16'h0000, 16'h0012, 16'h0000, 16'h0006, 0);
    add("after_flush", 0, 0, 0, 16'h0000, 16'h0014, 16'hA012, 16'h0014, 1);
    add("redir_fffe",  0, 0, 1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0014, 0);
    add("wrap",        0, 0, 0, 16'h0000, 16'h0000, 16'h5FFE, 16'h0000, 1);
    add("post_wrap",   0, 0, 0, 16'h0000, 16'h0002, 16'hA000, 16'h0002, 1);
    add("flush_stall", 1, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 0);

    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    rst_n = 1'b0;
    #12;
    check_state("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].redirect_pc);
      check_state(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pc2, vecs[i].exp_valid);
    end

`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, exp_fetch);
    check("stall_count", stall_count, exp_stall);
`endif

    // Move away from reset values, then flush+stall with a mid-cycle reset pulse.
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    check_state("pre_rst", 16'h0006, 16'h0002, 16'h0006, 1'b1);
    step(1, 1, 0, 16'h0000);
    check_state("fs_hold", 16'h0006, 16'h0000, 16'h0006, 1'b0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    #2 rst_n = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_rst", fetch_count, 32'd0);
    check("stall_rst", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    check_state("rst_override", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 0, 16'h0000);
    check_state("first_capture", 16'h0002, 16'hA000, 16'h0002, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
